io_rx_framer: RTL and testbench

- Receive-side framer directly downstream of the 8-bit IO bus interface.
- Consumes the demod byte stream (demo_data, valid only while mode_sel=1) one byte per sample strobe.
- Hunts for a sync byte, then reads a length byte, payload and XOR checksum.
- Buffers each frame store-and-forward in an internal FIFO and releases only checksum-good frames to the demodulator core over a valid/ready stream.

---
 rtl/io_rx_framer_if.sv | 16 +
 rtl/io_rx_framer.sv | 214 +++++++++++++++++++++
 tb/tb_io_rx_framer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_rx_framer_if.sv
// Output stream of the receive framer: committed payload bytes toward the
// demodulator core over a valid/ready handshake.
//   out_data  : payload byte (show-ahead)
//   out_last  : last byte of a frame
//   out_valid : committed byte available
//   out_ready : consumer accepts the byte when out_valid & out_ready
// master = framer side, slave = consumer side.
interface io_rx_framer_if;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_last, output out_valid, input out_ready);
  modport slave  (input out_data, input out_last, input out_valid, output out_ready);
endinterface

// File: rtl/io_rx_framer.sv
// Receive-side framer. Hunts for SYNC_BYTE, reads a length byte and the
// payload (plus an XOR checksum byte when RX_CHKSUM_EN is defined), stores
// the frame in a store-and-forward FIFO and only releases frames that were
// committed. Uncommitted bytes are rolled back on any error or abort.
//
// Optional feature macro: RX_CHKSUM_EN (checksum byte and CHK state).
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   mode_sel   : 1 = RX active, 0 = framer idle (aborts any frame in flight)
//   demo_data  : byte from the IO bus interface
//   sample_en  : one-cycle strobe, demo_data holds a new byte
//   bus        : committed payload stream (io_rx_framer_if.master)
//   frame_ok   : one-cycle pulse, frame committed
//   frame_err  : one-cycle pulse, frame discarded
//   overflow   : sticky, a frame was dropped for lack of FIFO space
//   busy       : framer is in any state other than HUNT
module io_rx_framer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_LEN    = 15,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_sel,
  input  logic [7:0]            demo_data,
  input  logic                  sample_en,
  io_rx_framer_if.master        bus,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned AW = PW + 1;
  localparam int unsigned FW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef RX_CHKSUM_EN
  localparam logic [1:0] ST_CHK     = 2'd3;
`endif

  logic [1:0]    state, state_n;
  logic [AW-1:0] wr_ptr, wr_n;
  logic [AW-1:0] commit_ptr, commit_n;
  logic [AW-1:0] rd_ptr, rd_n;
  logic [7:0]    cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic          ok_n, err_n, ovf_n;
  logic          we;
  logic [8:0]    wdata;
`ifdef RX_CHKSUM_EN
  logic [7:0]    chk, chk_n;
`endif

  logic [8:0]    mem [FIFO_DEPTH];
  logic [8:0]    rd_entry;
  logic [AW-1:0] used;
  logic [FW-1:0] free;
  logic          accept;
  logic          pop;

  assign accept = sample_en & mode_sel;
  assign used   = wr_ptr - rd_ptr;
  assign free   = FW'(FIFO_DEPTH) - {1'b0, used};

  // Show-ahead read side; drains independently of mode_sel.
  assign rd_entry      = mem[rd_ptr[PW-1:0]];
  assign bus.out_data  = rd_entry[7:0];
  assign bus.out_last  = rd_entry[8];
  assign bus.out_valid = (rd_ptr != commit_ptr);
  assign pop           = bus.out_valid & bus.out_ready;

  // Next-state, pointer and pulse logic.
  always_comb begin
    state_n  = state;
    wr_n     = wr_ptr;
    commit_n = commit_ptr;
    rd_n     = rd_ptr + AW'(pop);
    cnt_n    = cnt;
    timer_n  = timer;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    ovf_n    = overflow;
    we       = 1'b0;
    wdata    = {(cnt == 8'd1), demo_data};
`ifdef RX_CHKSUM_EN
    chk_n    = chk;
`endif

    if (!mode_sel) begin
      // Silent abort: drop the frame in flight, keep committed data.
      state_n = ST_HUNT;
      wr_n    = commit_ptr;
      timer_n = '0;
    end else if (state != ST_HUNT && !accept && timer == TW'(TIMEOUT - 1)) begin
      state_n = ST_HUNT;
      wr_n    = commit_ptr;
      timer_n = '0;
      err_n   = 1'b1;
    end else begin
      if (state != ST_HUNT)
        timer_n = accept ? '0 : timer + TW'(1);

      case (state)
        ST_HUNT: begin
          timer_n = '0;
          if (accept && demo_data == SYNC_BYTE)
            state_n = ST_LEN;
        end

        ST_LEN: begin
          if (accept) begin
            if (demo_data == 8'd0 || 32'(demo_data) > MAX_LEN) begin
              state_n = ST_HUNT;
              err_n   = 1'b1;
            end else if (32'(demo_data) > 32'(free)) begin
              state_n = ST_HUNT;
              err_n   = 1'b1;
              ovf_n   = 1'b1;
            end else begin
              state_n = ST_PAYLOAD;
              cnt_n   = demo_data;
`ifdef RX_CHKSUM_EN
              chk_n   = demo_data;
`endif
            end
          end
        end

        ST_PAYLOAD: begin
          if (accept) begin
            we    = 1'b1;
            wr_n  = wr_ptr + AW'(1);
            cnt_n = cnt - 8'd1;
`ifdef RX_CHKSUM_EN
            chk_n = chk ^ demo_data;
            if (cnt == 8'd1)
              state_n = ST_CHK;
`else
            if (cnt == 8'd1) begin
              commit_n = wr_ptr + AW'(1);
              ok_n     = 1'b1;
              state_n  = ST_HUNT;
            end
`endif
          end
        end

`ifdef RX_CHKSUM_EN
        ST_CHK: begin
          if (accept) begin
            state_n = ST_HUNT;
            if (demo_data == chk) begin
              commit_n = wr_ptr;
              ok_n     = 1'b1;
            end else begin
              wr_n  = commit_ptr;
              err_n = 1'b1;
            end
          end
        end
`endif

        default: state_n = ST_HUNT;
      endcase
    end
  end

  // State, pointer and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      timer      <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
`ifdef RX_CHKSUM_EN
      chk        <= '0;
`endif
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_n;
      commit_ptr <= commit_n;
      rd_ptr     <= rd_n;
      cnt        <= cnt_n;
      timer      <= timer_n;
      frame_ok   <= ok_n;
      frame_err  <= err_n;
      overflow   <= ovf_n;
      busy       <= (state_n != ST_HUNT);
`ifdef RX_CHKSUM_EN
      chk        <= chk_n;
`endif
    end
  end

  // Payload storage; pointers alone define validity, so no reset needed.
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_io_rx_framer.sv
// Directed self-checking bench for io_rx_framer. Follows the RX_CHKSUM_EN
// setting of the build: checksum bytes are only sent when it is defined.
module tb_io_rx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_sel;
  logic [7:0] demo_data;
  logic       sample_en;
  logic       frame_ok, frame_err, overflow, busy;

  io_rx_framer_if bus ();

  io_rx_framer dut (
    .clk       (clk),
    .rst       (rst),
    .mode_sel  (mode_sel),
    .demo_data (demo_data),
    .sample_en (sample_en),
    .bus       (bus),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int committed = 0;
  logic [7:0] got_d [$];
  logic       got_l [$];

  // Record pulses and accepted output bytes mid-cycle.
  always @(negedge clk) begin
    if (frame_ok)  ok_cnt++;
    if (frame_err) err_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.out_data);
      got_l.push_back(bus.out_last);
    end
  end

  task automatic send(input logic [7:0] b);
    demo_data = b;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    ok_cnt = 0;
    err_cnt = 0;
    got_d.delete();
    got_l.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_sel = 1'b1; demo_data = 8'hA5; sample_en = 1'b1;
    bus.out_ready = 1'b1;
    idle(3);
    sample_en = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if ({frame_ok, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {frame_ok, frame_err}); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_good_frame();
    logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    clear_mon();
    bus.out_ready = 1'b1;
    send(8'h5A); send(8'hA5); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
`ifdef RX_CHKSUM_EN
    checks++; if (bus.out_valid !== 1'b0 || got_d.size() != 0) begin errors++; $display("FAIL good_early_out got valid=%b n=%0d exp 0/0", bus.out_valid, got_d.size()); end
    send(8'h03);
`endif
    idle(4);
    checks++; if (ok_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL good_pulses got ok=%0d err=%0d exp 1/0", ok_cnt, err_cnt); end
    checks++; if (got_d.size() != 3) begin errors++; $display("FAIL good_count got %0d exp 3", got_d.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
        errors++; $display("FAIL good_byte%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], (i == 2));
      end
    end
    committed += 3;
  endtask

  task automatic test_bad_checksum();
    logic [4:0] exp_p;
    clear_mon();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
`ifdef RX_CHKSUM_EN
    send(8'h04);
    idle(4);
    checks++; if (err_cnt != 1 || ok_cnt != 0) begin errors++; $display("FAIL badchk_pulses got ok=%0d err=%0d exp 0/1", ok_cnt, err_cnt); end
    checks++; if (got_d.size() != 0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL badchk_output got n=%0d valid=%b exp 0/0", got_d.size(), bus.out_valid); end
`else
    send(8'h04);
    idle(4);
    checks++; if (ok_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL nochk_pulses got ok=%0d err=%0d exp 1/0", ok_cnt, err_cnt); end
    checks++; if (got_d.size() != 3) begin errors++; $display("FAIL nochk_count got %0d exp 3", got_d.size()); end
    committed += 3;
`endif
    exp_p = 5'(committed);
    checks++; if (dut.wr_ptr !== exp_p || dut.commit_ptr !== exp_p) begin errors++; $display("FAIL badchk_ptrs got wr=%0d commit=%0d exp %0d", dut.wr_ptr, dut.commit_ptr, exp_p); end
  endtask

  task automatic test_sync_in_payload();
    clear_mon();
    send(8'hA5); send(8'h02); send(8'hA5); send(8'h01);
`ifdef RX_CHKSUM_EN
    send(8'hA6);
`endif
    idle(4);
    checks++; if (ok_cnt != 1 || got_d.size() != 2) begin errors++; $display("FAIL syncdata got ok=%0d n=%0d exp 1/2", ok_cnt, got_d.size()); end
    else begin
      checks++; if (got_d[0] !== 8'hA5 || got_d[1] !== 8'h01 || got_l[1] !== 1'b1) begin errors++; $display("FAIL syncdata_bytes got %h %h last=%b exp a5 01 1", got_d[0], got_d[1], got_l[1]); end
    end
    committed += 2;
  endtask

  task automatic test_overflow();
    logic [7:0] c = 8'h0A;
    clear_mon();
    bus.out_ready = 1'b0;
    send(8'hA5); send(8'h0A);
    for (int i = 0; i < 10; i++) begin
      send(8'h10 + 8'(i));
      c = c ^ (8'h10 + 8'(i));
    end
`ifdef RX_CHKSUM_EN
    send(c);
`endif
    idle(2);
    checks++; if (ok_cnt != 1 || bus.out_valid !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_first got ok=%0d valid=%b ovf=%b exp 1/1/0", ok_cnt, bus.out_valid, overflow); end
    send(8'hA5); send(8'h0F);
    idle(2);
    checks++; if (err_cnt != 1 || overflow !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovf_second got err=%0d ovf=%b busy=%b exp 1/1/0", err_cnt, overflow, busy); end
    bus.out_ready = 1'b1;
    idle(15);
    checks++; if (got_d.size() != 10) begin errors++; $display("FAIL ovf_drain_count got %0d exp 10", got_d.size()); end
    else for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_d[i] !== 8'h10 + 8'(i) || got_l[i] !== (i == 9)) begin
        errors++; $display("FAIL ovf_byte%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], 8'h10 + 8'(i), (i == 9));
      end
    end
    committed += 10;
  endtask

  task automatic test_illegal_len();
    clear_mon();
    send(8'hA5); send(8'h00);
    idle(1);
    checks++; if (busy !== 1'b0 || err_cnt != 1) begin errors++; $display("FAIL len0 got busy=%b err=%0d exp 0/1", busy, err_cnt); end
    send(8'hA5); send(8'h10);
    idle(1);
    checks++; if (busy !== 1'b0 || err_cnt != 2) begin errors++; $display("FAIL len16 got busy=%b err=%0d exp 0/2", busy, err_cnt); end
    send(8'hA5); send(8'h01); send(8'h7E);
`ifdef RX_CHKSUM_EN
    send(8'h7F);
`endif
    idle(3);
    checks++; if (ok_cnt != 1 || got_d.size() != 1) begin errors++; $display("FAIL len1 got ok=%0d n=%0d exp 1/1", ok_cnt, got_d.size()); end
    else begin
      checks++; if (got_d[0] !== 8'h7E || got_l[0] !== 1'b1) begin errors++; $display("FAIL len1_byte got %h/%b exp 7e/1", got_d[0], got_l[0]); end
    end
    committed += 1;
  endtask

  task automatic test_abort();
    clear_mon();
    send(8'hA5); send(8'h03); send(8'h11);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b exp 1", busy); end
    mode_sel = 1'b0;
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    idle(3);
    checks++; if (err_cnt != 0 || got_d.size() != 0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_silent got err=%0d n=%0d valid=%b exp 0/0/0", err_cnt, got_d.size(), bus.out_valid); end
    mode_sel = 1'b1;
    send(8'hA5); send(8'h02); send(8'h66); send(8'h77);
`ifdef RX_CHKSUM_EN
    send(8'h13);
`endif
    idle(3);
    checks++; if (ok_cnt != 1 || got_d.size() != 2) begin errors++; $display("FAIL abort_resume got ok=%0d n=%0d exp 1/2", ok_cnt, got_d.size()); end
    else begin
      checks++; if (got_d[0] !== 8'h66 || got_d[1] !== 8'h77 || got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin errors++; $display("FAIL abort_resume_bytes got %h %h exp 66 77", got_d[0], got_d[1]); end
    end
    committed += 2;
  endtask

  task automatic test_timeout();
    int hit = 0;
    logic [4:0] exp_p;
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h44);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (frame_err) begin hit = k; break; end
    end
    checks++; if (hit != 255) begin errors++; $display("FAIL timeout_cycle got %0d exp 255", hit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b exp 0", busy); end
    idle(2);
    exp_p = 5'(committed);
    checks++; if (got_d.size() != 0 || dut.wr_ptr !== exp_p) begin errors++; $display("FAIL timeout_rollback got n=%0d wr=%0d exp 0/%0d", got_d.size(), dut.wr_ptr, exp_p); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_sync_in_payload();
    test_overflow();
    test_illegal_len();
    test_abort();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
